// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational first-requester search starting at ptr, wrapping modulo N.
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  requests,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);
    localparam logic [IW:0] NV = (IW+1)'(N);
    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;
    always_comb begin
        rot = N'({requests, requests} >> ptr);
        off = '0;
        for (int j = N - 1; j >= 0; j--) if (rot[j]) off = IW'(j);
        sum = {1'b0, ptr} + {1'b0, off};
        index = (sum >= NV) ? IW'(sum - NV) : IW'(sum);
        any = |requests;
        grant = any ? (N'(1) << index) : '0;
    end
endmodule

// File: rtl/round_robin_arbiter_with_burst_limit.sv
// round_robin_arbiter_with_burst_limit: round-robin arbiter letting an owner hold the grant up to MAX_BURST cycles.
module round_robin_arbiter_with_burst_limit #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           requests,
    output logic [N_REQ-1:0]           grants,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       last
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_BURST);
    localparam logic [IW-1:0] LAST_ID = IW'(N_REQ - 1);
    if (N_REQ < 2) begin : g_bad_n
        $error("N_REQ must be >= 2");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("MAX_BURST must be >= 1");
    end
    logic [IW-1:0]    ptr, owner, pick_idx;
    logic             owner_vld, pick_any, hold, active;
    logic [CW-1:0]    cnt, next_cnt;
    logic [N_REQ-1:0] pick_grant;
    rr_priority_pick #(.N(N_REQ)) u_pick (
        .requests(requests),
        .ptr     (ptr),
        .grant   (pick_grant),
        .index   (pick_idx),
        .any     (pick_any)
    );
    always_comb begin
        hold     = owner_vld && requests[owner] && (cnt < MAX_C);
        active   = !rst && (hold || pick_any);
        grant_id = !active ? '0 : hold ? owner : pick_idx;
        grants   = !active ? '0 : hold ? (N_REQ'(1) << owner) : pick_grant;
        next_cnt = hold ? cnt + 1'b1 : CW'(1);
        last     = active && (next_cnt == MAX_C);
    end
    // ptr always moves past the granted index, so an expiring owner drops to lowest priority
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            cnt       <= '0;
        end else if (active) begin
            ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            owner     <= grant_id;
            owner_vld <= 1'b1;
            cnt       <= next_cnt;
        end else begin
            owner_vld <= 1'b0;
            cnt       <= '0;
        end
    end
endmodule
